// File: rtl/cordic_sum_sequencer_pkg.sv
// Shared types and constants for the Cordic-sum sequencer.
// Holds the FSM state enum, the data word width and the IEEE-754 constants
// used for sum initialisation.
package cordic_sum_sequencer_pkg;

  // Every data path in the sequencer carries one IEEE-754 single word.
  localparam int WORD_W = 32;

  // Sums and results are opaque words here; these constants only name
  // the encodings the sequencer loads or that callers commonly expect.
  localparam logic [WORD_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [WORD_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IN   = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_FINISH    = 3'd4
  } seq_state_e;

endpackage : cordic_sum_sequencer_pkg

// File: rtl/cordic_seq_watchdog.sv
// Purpose : counts consecutive enabled cycles and flags expiry after TIMEOUT_CYCLES.
// Latency : o_expire is combinational, high in the TIMEOUT_CYCLES-th enabled cycle.
// Backpres: none; the owner decides what to do with the expiry.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   i_clear       synchronous clear, has priority over i_enable
//   i_enable      count this cycle
//   o_expire      this is the last allowed enabled cycle
module cordic_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  // One extra bit of headroom keeps TIMEOUT_CYCLES = 1 and powers of two legal.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_enable && !i_clear && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expire) begin
      // Saturate at LAST; the owner leaves the enabling state on expiry.
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : cordic_seq_watchdog

// File: rtl/cordic_sum_sequencer.sv
// Purpose : runs n launches of a stateless cos(a)+b core, feeding each partial sum back as b.
// Latency : 1 + n*(2+L) + 1 cycles from start to done (L = core latency); n=0 finishes next cycle.
// Backpres: in_ready is high only while waiting for a sample; the core is never relaunched before core_done.
//
// Ports:
//   clk, reset_n             clock and asynchronous active-low reset
//   start, n                 one-cycle request with element count (ignored while busy)
//   in_data/in_valid/in_ready  sample stream (valid/ready handshake)
//   core_dataa/core_datab    x and running sum presented to the core
//   core_start               one-cycle launch pulse to the core
//   core_result/core_done    core answer and its one-cycle completion pulse
//   busy, result, done       status, final sum (held until next start), completion pulse
//   error                    core timeout flag
//
// Optional feature: define CORDIC_SEQ_TIMEOUT_EN to abort a sequence when the core
// stays silent for TIMEOUT_CYCLES cycles; without it error is constant 0.
module cordic_sum_sequencer
  import cordic_sum_sequencer_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] core_dataa,
  output logic [WORD_W-1:0] core_datab,
  output logic              core_start,
  input  logic [WORD_W-1:0] core_result,
  input  logic              core_done,
  output logic              busy,
  output logic [WORD_W-1:0] result,
  output logic              done,
  output logic              error
);

  seq_state_e r_state;
  seq_state_e w_next;

  logic [WORD_W-1:0] r_sum;
  logic [WORD_W-1:0] r_dataa;
  logic [WORD_W-1:0] r_result;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_n;
  logic              r_error;

  // Strobes from the FSM to the datapath registers.
  logic w_seq_init;   // start with n != 0
  logic w_zero_start; // start with n == 0
  logic w_accept;     // sample handshake
  logic w_step;       // core completed one operation
  logic w_last;       // ... and it was the final one
  logic w_tmo;        // core watchdog fired

  // Count+1 is formed one bit wider so n = 2^CNT_W-1 is reached before any wrap.
  logic [CNT_W:0] w_count_inc;
  assign w_count_inc = {1'b0, r_count} + 1'b1;

  logic w_expire;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  logic w_in_core;
  assign w_in_core = (r_state == ST_WAIT_CORE);

  // Cleared whenever we are not waiting on the core, so each launch gets a
  // fresh TIMEOUT_CYCLES budget.
  cordic_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (!w_in_core),
    .i_enable (w_in_core),
    .o_expire (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_expire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_seq_init   = 1'b0;
    w_zero_start = 1'b0;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    w_tmo        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (n != '0) begin
            w_seq_init = 1'b1;
            w_next     = ST_WAIT_IN;
          end else begin
            w_zero_start = 1'b1;
            w_next       = ST_FINISH;
          end
        end
      end

      ST_WAIT_IN: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        w_next = ST_WAIT_CORE;
      end

      ST_WAIT_CORE: begin
        if (core_done) begin
          w_step = 1'b1;
          if (w_count_inc == {1'b0, r_n}) begin
            w_last = 1'b1;
            w_next = ST_FINISH;
          end else begin
            w_next = ST_WAIT_IN;
          end
        end else if (w_expire) begin
          w_tmo  = 1'b1;
          w_next = ST_FINISH;
        end
      end

      ST_FINISH: begin
        w_next = ST_IDLE;
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: sum, count, latched sample, result, error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum    <= FP_ZERO;
      r_dataa  <= FP_ZERO;
      r_result <= FP_ZERO;
      r_count  <= '0;
      r_n      <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_seq_init) begin
        r_sum    <= FP_ZERO;
        r_count  <= '0;
        r_n      <= n;
        r_result <= FP_ZERO;
        r_error  <= 1'b0;
      end

      if (w_zero_start) begin
        r_result <= FP_ZERO;
        r_error  <= 1'b0;
      end

      if (w_accept) begin
        r_dataa <= in_data;
      end

      // The partial sum only moves on core_done, which keeps core_datab
      // stable for the whole launch-to-done window.
      if (w_step) begin
        r_sum   <= core_result;
        r_count <= w_count_inc[CNT_W-1:0];
        if (w_last) begin
          r_result <= core_result;
        end
      end

      // A timed-out sequence reports whatever sum had been reached.
      if (w_tmo) begin
        r_error  <= 1'b1;
        r_result <= r_sum;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all control outputs decode directly from state, so an async reset
  // drops them in the same instant it forces IDLE.
  // ---------------------------------------------------------------------------
  assign in_ready   = (r_state == ST_WAIT_IN);
  assign core_start = (r_state == ST_LAUNCH);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FINISH);
  assign core_dataa = r_dataa;
  assign core_datab = r_sum;
  assign result     = r_result;
  assign error      = r_error;

endmodule : cordic_sum_sequencer

// File: tb/tb_cordic_sum_sequencer.sv
// Bench for cordic_sum_sequencer with a behavioural cos(a)+b core (5-cycle latency).
// Table-driven sequences plus hand-written reset and timeout scenarios.
// Timeout scenario is selected by CORDIC_SEQ_TIMEOUT_EN, matching the RTL build.
module tb_cordic_sum_sequencer;
  import cordic_sum_sequencer_pkg::*;

  localparam int CNT_W = 16;
  localparam logic [31:0] PI_S   = 32'h4049_0FDB;
  localparam logic [31:0] PIH_S  = 32'h3FC9_0FDB;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [CNT_W-1:0]  n;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       core_dataa;
  logic [31:0]       core_datab;
  logic              core_start;
  logic [31:0]       core_result;
  logic              core_done;
  logic              busy;
  logic [31:0]       result;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  cordic_sum_sequencer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .n           (n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .core_dataa  (core_dataa),
    .core_datab  (core_datab),
    .core_start  (core_start),
    .core_result (core_result),
    .core_done   (core_done),
    .busy        (busy),
    .result      (result),
    .done        (done),
    .error       (error)
  );

  // ---------------------------------------------------------------------------
  // Float helpers
  // ---------------------------------------------------------------------------
  function automatic real sp2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    e = {24'd0, b[30:23]};
    e = e - 127;
    r = 1.0 + $itor({9'd0, b[22:0]}) / 8388608.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [30:0] mag;
    int          e;
    d = $realtobits(r);
    e = {21'd0, d[62:52]};
    if (e == 0) return 32'd0;
    e = e - 1023 + 127;
    if (e <= 0)   return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    mag = {e[7:0], d[51:29]};
    if (d[28] && ((|d[27:0]) || mag[0])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural core: done 5 cycles after the core_start cycle
  // ---------------------------------------------------------------------------
  logic [4:0]  r_sr      = '0;
  logic [31:0] r_res     = '0;
  logic        core_mute = 1'b0;
  logic        spur_done = 1'b0;

  always @(posedge clk) begin
    r_sr <= {r_sr[3:0], core_start & ~core_mute};
    if (core_start) r_res <= r2sp($cos(sp2r(core_dataa)) + sp2r(core_datab));
  end

  assign core_done   = r_sr[4] | spur_done;
  assign core_result = r_res;

  // ---------------------------------------------------------------------------
  // Cycle counter and cumulative monitors (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int n_core_start = 0;
  int n_done = 0;
  int n_in_ready = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_start) n_core_start <= n_core_start + 1;
    if (in_ready)   n_in_ready   <= n_in_ready + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input logic [31:0] act, input real exp);
    real a, diff;
    checks++;
    a = sp2r(act);
    diff = a - exp;
    if (diff < 0.0) diff = -diff;
    if (!(diff < 1.0e-4)) begin
      errors++;
      $display("FAIL %s: got %h (%f), expected %f within 1e-4", name, act, a, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [CNT_W-1:0] n;
    logic [3:0][31:0] x;
    bit               gap;
    bit               approx;
    logic [31:0]      exp_res;
    real              exp_val;
    int               exp_cyc;   // done cycle counting the start cycle as 1; 0 = not checked
  } vec_t;

  function automatic vec_t mkv(input int nn, input logic [31:0] x0, input logic [31:0] x1,
                               input logic [31:0] x2, input logic [31:0] x3, input bit gap,
                               input bit approx, input logic [31:0] er, input real ev,
                               input int ec);
    vec_t v;
    v.n       = CNT_W'(nn);
    v.x       = {x3, x2, x1, x0};
    v.gap     = gap;
    v.approx  = approx;
    v.exp_res = er;
    v.exp_val = ev;
    v.exp_cyc = ec;
    return v;
  endfunction

  // One sample handshake; in gap mode waits for in_ready, then idles 3 cycles
  // while injecting a spurious core_done and an ignored start pulse.
  task automatic feed_one(input logic [31:0] x, input bit gap);
    bit acc;
    int k;
    if (gap) begin
      in_valid = 1'b0;
      k = 0;
      acc = 1'b0;
      while (!acc && k < 200) begin
        @(negedge clk);
        acc = in_ready;
        k++;
      end
      if (!acc) fail_timeout("gap_wait_in_ready");
      @(posedge clk); #1;
      spur_done = 1'b1;
      @(posedge clk); #1;
      spur_done = 1'b0;
      start = 1'b1;
      n = CNT_W'(1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_data  = x;
    in_valid = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      k++;
    end
    if (!acc) fail_timeout("accept");
  endtask

  task automatic run_vec(input vec_t v, output logic [31:0] res, output int ncs,
                         output int nd, output int dcyc, output int nrdy);
    int cs0, d0, r0, c0, k;
    @(posedge clk); #1;
    cs0 = n_core_start;
    d0  = n_done;
    r0  = n_in_ready;
    c0  = cyc;
    start    = 1'b1;
    n        = v.n;
    in_valid = !v.gap;
    in_data  = v.x[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < int'(v.n) && i < 4; i++) feed_one(v.x[i], v.gap);
    k = 0;
    while (n_done == d0 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_done == d0) fail_timeout("wait_done");
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    res  = result;
    ncs  = n_core_start - cs0;
    nd   = n_done - d0;
    dcyc = done_cyc - c0 + 1;
    nrdy = n_in_ready - r0;
  endtask

  vec_t tbl[8];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] res;
    int ncs, nd, dcyc, nrdy, d0, a, k;

    tbl[0] = mkv(3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4040_0000, 3.0, 23);
    tbl[1] = mkv(2, 32'h0, PI_S,  32'h0, 32'h0, 1'b0, 1'b1, 32'h0,        0.0, 16);
    tbl[2] = mkv(0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, FP_ZERO,      0.0, 2);
    tbl[3] = mkv(1, PI_S,  32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hBF80_0000, -1.0, 9);
    tbl[4] = mkv(4, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4080_0000, 4.0, 30);
    tbl[5] = mkv(2, 32'h0, PIH_S, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0,        1.0, 16);
    tbl[6] = mkv(3, 32'h0, PI_S,  32'h0, 32'h0, 1'b1, 1'b0, FP_ONE,       1.0, 0);
    tbl[7] = mkv(3, 32'h0, PI_S,  32'h0, 32'h0, 1'b0, 1'b0, FP_ONE,       1.0, 23);

    reset_n  = 1'b0;
    start    = 1'b0;
    n        = '0;
    in_data  = '0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready",   {31'd0, in_ready},   32'd0);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_error",      {31'd0, error},      32'd0);
    chk("rst_result",     result,              FP_ZERO);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven runs
    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], res, ncs, nd, dcyc, nrdy);
      if (tbl[i].approx) chk_near($sformatf("v%0d_result", i), res, tbl[i].exp_val);
      else               chk($sformatf("v%0d_result", i), res, tbl[i].exp_res);
      chk($sformatf("v%0d_core_starts", i), ncs, {16'd0, tbl[i].n});
      chk($sformatf("v%0d_done_pulses", i), nd, 32'd1);
      if (tbl[i].exp_cyc != 0) chk($sformatf("v%0d_done_cycle", i), dcyc, tbl[i].exp_cyc);
      if (tbl[i].n == '0) chk($sformatf("v%0d_in_ready_cycles", i), nrdy, 32'd0);
      chk($sformatf("v%0d_error", i), {31'd0, error}, 32'd0);
      chk($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    // Reset in the second WAIT_CORE of an n=3 run
    @(posedge clk); #1;
    start = 1'b1;
    n = CNT_W'(3);
    in_valid = 1'b1;
    in_data = FP_ONE;
    @(posedge clk); #1;
    start = 1'b0;
    feed_one(FP_ONE, 1'b0);
    feed_one(FP_ONE, 1'b0);
    @(posedge clk); #1;
    chk("mid_busy_before_reset", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",   {31'd0, in_ready},   32'd0);
    chk("mid_rst_core_start", {31'd0, core_start}, 32'd0);
    chk("mid_rst_busy",       {31'd0, busy},       32'd0);
    chk("mid_rst_done",       {31'd0, done},       32'd0);
    chk("mid_rst_dataa",      core_dataa,          FP_ZERO);
    chk("mid_rst_datab",      core_datab,          FP_ZERO);
    chk("mid_rst_result",     result,              FP_ZERO);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    d0 = n_done;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_done", n_done - d0, 32'd0);
    chk("post_rst_idle",    {31'd0, busy}, 32'd0);
    run_vec(mkv(1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, FP_ONE, 1.0, 9),
            res, ncs, nd, dcyc, nrdy);
    chk("post_rst_result",     res,  FP_ONE);
    chk("post_rst_done_cycle", dcyc, 32'd9);

`ifdef CORDIC_SEQ_TIMEOUT_EN
    // Core never answers: 64 cycles of WAIT_CORE, then FINISH with error.
    core_mute = 1'b1;
    d0 = n_done;
    @(posedge clk); #1;
    start = 1'b1;
    n = CNT_W'(2);
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    feed_one(32'h0, 1'b0);
    a = cyc;
    in_valid = 1'b0;
    k = 0;
    while (n_done == d0 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_done == d0) fail_timeout("tmo_wait_done");
    chk("tmo_done_cycle", done_cyc - a, 32'd65);
    chk("tmo_error",      {31'd0, error}, 32'd1);
    chk("tmo_result",     result, FP_ZERO);
    repeat (4) @(posedge clk);
    #1;
    chk("tmo_error_held", {31'd0, error}, 32'd1);
    chk("tmo_single_done", n_done - d0, 32'd1);
    core_mute = 1'b0;
    run_vec(mkv(0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, FP_ZERO, 0.0, 2),
            res, ncs, nd, dcyc, nrdy);
    chk("tmo_error_cleared", {31'd0, error}, 32'd0);
`else
    // Core never answers: the sequencer waits indefinitely without error.
    core_mute = 1'b1;
    d0 = n_done;
    @(posedge clk); #1;
    start = 1'b1;
    n = CNT_W'(1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    feed_one(32'h0, 1'b0);
    in_valid = 1'b0;
    a = 0;
    k = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("hang_busy",    {31'd0, busy},  32'd1);
    chk("hang_error",   {31'd0, error}, 32'd0);
    chk("hang_no_done", n_done - d0,    32'd0);
    reset_n = 1'b0;
    #1;
    chk("hang_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    core_mute = 1'b0;
    repeat (8) @(posedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule : tb_cordic_sum_sequencer

// File: doc/cordic_sum_sequencer.md
# cordic_sum_sequencer

Feeds the Cordic-sum stage: takes a stream of IEEE-754 single-precision samples, launches one cos(x)+sum operation per sample, and feeds each partial sum back as the next addend. When the programmed element count is reached it returns the final sum. It sits between the Nios-II multicycle custom-instruction / DMA front end and the Cordic-sum top (cos(dataa)+datab). It owns the accumulation state, so the arithmetic stage can stay stateless.

## Interface
- CNT_W, 16, width of element count `n`
- TIMEOUT_CYCLES, 64, watchdog limit on `core_done` (used only with `CORDIC_SEQ_TIMEOUT_EN`)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; samples `n`
- n  in  CNT_W  number of samples to accumulate
- in_data  in  32  sample x, IEEE-754 single
- in_valid  in  1  `in_data` valid
- in_ready  out  1  sequencer accepts a sample this cycle
- core_dataa  out  32  x to the core
- core_datab  out  32  running sum to the core
- core_start  out  1  one-cycle launch pulse to the core
- core_result  in  32  cos(x)+sum from the core
- core_done  in  1  one-cycle completion pulse from the core
- busy  out  1  sequence in progress
- result  out  32  final sum, held until the next `start`
- done  out  1  one-cycle completion pulse
- error  out  1  timeout flag (tied 0 without `CORDIC_SEQ_TIMEOUT_EN`)

## Operation
- States: IDLE, WAIT_IN, LAUNCH, WAIT_CORE, FINISH.
- **IDLE:**
  - `start` and `n`≠0 → WAIT_IN. Sum ← 0x00000000, count ← 0, `n` latched, `result` ← 0x00000000, `error` ← 0.
  - `start` and `n`=0 → FINISH. `result` = 0x00000000.
- **WAIT_IN:** `in_ready`=1. On `in_valid` && `in_ready`, `in_data` is latched into `core_dataa` → LAUNCH.
- **LAUNCH:**
  - `core_start`=1 for exactly one cycle.
  - `core_datab` = current sum; stable from LAUNCH until `core_done`.
  - → WAIT_CORE.
- **WAIT_CORE:** on `core_done`, sum ← `core_result` and count ← count+1.
  - count+1 == `n` → FINISH; `result` ← `core_result` on the same edge.
  - Otherwise → WAIT_IN.
- **FINISH:** `done`=1 for one cycle → IDLE.
- `busy` = (state ≠ IDLE).
- `start` while `busy` is ignored.
- `core_done` outside WAIT_CORE is ignored.
- No float arithmetic happens in this block. Sum and result are opaque 32-bit words.
- Count compare is unsigned. `n` = 2^CNT_W−1 is legal; count must not wrap before reaching it.

## Timing
- Reset values: `in_ready`, `core_start`, `busy`, `done`, `error` = 0. `core_dataa`, `core_datab`, `result` = 0x00000000. State = IDLE.
- `start` at edge T → `busy`=1 after T. `in_ready`=1 after T (n≠0).
- Accept at edge A → `core_start` high in cycle A+1.
- Per-sample overhead is 2 cycles plus core latency L. Minimum `done` latency from `start`: 1 + n·(2+L) + 1 cycles.
- `n`=0: `done` is high in the cycle after `start`.
- `in_ready` is 0 outside WAIT_IN. `in_valid` held through a gap is not consumed twice.
- Reset asserted mid-operation: all outputs go to reset values immediately. The in-flight core operation is abandoned; its later `core_done` is ignored.

## Configuration
- Macro: `CORDIC_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WAIT_CORE.
  - If it reaches TIMEOUT_CYCLES without `core_done`: `error` ← 1, `result` ← last sum, `done` pulses via FINISH, state → IDLE.
  - `error` holds until the next `start`.
- **Undefined:** no counter. WAIT_CORE waits indefinitely. `error` is constant 0.

## Structure
- Shared package holds:
  - state enum (5 states)
  - `FP_ZERO` = 32'h00000000
  - `FP_ONE` = 32'h3F800000
  - the 32-bit word width constant
- One natural sub-module: `cordic_seq_watchdog` (clear/enable/expire counter). It is instantiated only under `CORDIC_SEQ_TIMEOUT_EN`.

## Test plan
The bench uses a behavioural core: cos(a)+b with 5-cycle latency, tolerance 1e-4.

- **Constant input:** `n`=3, samples 0x00000000 ×3 → `result` 0x40400000 (3.0). `done` 1 cycle, at cycle 1+3·7+1 = 23 after `start`.
- **Cancellation:** `n`=2, samples 0x00000000 then 0x40490FDB (π) → `result` ≈ 0.0 (|r| < 1e-4).
- **Zero count:** `n`=0 → `done` in the cycle after `start`, `result` 0x00000000, `in_ready` never 1, `core_start` never 1.
- **Backpressure and ignored inputs:** `in_valid` toggled with 3-cycle gaps; extra `start` pulses mid-run; spurious `core_done` in WAIT_IN → exactly `n` `core_start` pulses and the same `result` as the gap-free run.
- **Reset mid-run:** `reset_n` low during the second WAIT_CORE → outputs at reset values. A following `n`=1, x=0 run → 0x3F800000.
- **Timeout (`CORDIC_SEQ_TIMEOUT_EN`):** core never responds → `error`=1 and `done` pulse after 64 cycles in WAIT_CORE, `result` = 0x00000000.
